// File: rtl/gpr_wb_pkg.sv
// Shared types and widths for the GPR writeback path.
// Used by gpr_wb_fifo and gpr_wb_arbiter (optional bypass port enabled by GPR_WB_BYPASS_EN).
package gpr_wb_pkg;

    localparam int GPR_AW = 5;
    localparam int GPR_DW = 32;

    typedef struct packed {
        logic [GPR_AW-1:0] rt;
        logic [GPR_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Circular queue of pending load writebacks; exposes occupancy, head and all
// entries reordered oldest-first so a bypass search can scan by age.
module gpr_wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   enq,
    input  wb_req_t                enq_req,
    input  logic                   deq,
    output logic [CW-1:0]          count,
    output wb_req_t                head,
    output wb_req_t [DEPTH-1:0]    entries
);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (deq)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge CLK) begin
        if (enq)
            mem[wr_ptr_reg] <= enq_req;
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // entries[0] is the head (oldest), entries[count-1] the tail (newest).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign entries[gi] = mem[rd_ptr_reg + AW'(gi)];
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter: ALU results win, queued load returns drain when idle or
// when starved. Define GPR_WB_BYPASS_EN to add the operand bypass search port.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_VLD,
    output logic              A_RDY,
    input  logic [GPR_AW-1:0] A_RT,
    input  logic [GPR_DW-1:0] A_DATA,
    input  logic              L_VLD,
    output logic              L_RDY,
    input  logic [GPR_AW-1:0] L_RT,
    input  logic [GPR_DW-1:0] L_DATA,
    output logic              WE,
    output logic [GPR_AW-1:0] RW,
    output logic [GPR_DW-1:0] DW,
    output logic [CW-1:0]     QCNT
`ifdef GPR_WB_BYPASS_EN
    ,
    input  logic [GPR_AW-1:0] BYP_R,
    output logic              BYP_HIT,
    output logic [GPR_DW-1:0] BYP_DATA
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] QFULL      = CW'(DEPTH);

    logic                  q_enq;
    logic                  q_deq;
    logic [CW-1:0]         q_count;
    wb_req_t               q_head;
    wb_req_t [DEPTH-1:0]   q_entries;
    wb_req_t               l_req;

    logic                  force_lsu;
    logic                  sel_alu;
    logic                  sel_lsu;

    logic [SW-1:0]         starve_reg, starve_next;
    logic                  we_reg, we_next;
    logic [GPR_AW-1:0]     rw_reg, rw_next;
    logic [GPR_DW-1:0]     dw_reg, dw_next;

    assign l_req.rt   = L_RT;
    assign l_req.data = L_DATA;

    gpr_wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .enq     (q_enq),
        .enq_req (l_req),
        .deq     (q_deq),
        .count   (q_count),
        .head    (q_head),
        .entries (q_entries)
    );

    // Both ready signals are forced low while reset is held.
    assign force_lsu = (q_count != '0) && (starve_reg >= STARVE_LIM);
    assign A_RDY     = RST_N && !force_lsu;
    assign L_RDY     = RST_N && (q_count != QFULL);

    assign sel_alu   = A_VLD && A_RDY;
    assign sel_lsu   = !sel_alu && (q_count != '0);
    assign q_enq     = L_VLD && L_RDY;
    assign q_deq     = sel_lsu;

    always_comb begin
        we_next     = 1'b0;
        rw_next     = rw_reg;
        dw_next     = dw_reg;
        starve_next = starve_reg;
        if (sel_alu) begin
            we_next = 1'b1;
            rw_next = A_RT;
            dw_next = A_DATA;
        end else if (sel_lsu) begin
            we_next = 1'b1;
            rw_next = q_head.rt;
            dw_next = q_head.data;
        end
        if ((q_count == '0) || sel_lsu)
            starve_next = '0;
        else if (starve_reg != STARVE_LIM)
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_reg     <= 1'b0;
            rw_reg     <= '0;
            dw_reg     <= '0;
            starve_reg <= '0;
        end else begin
            we_reg     <= we_next;
            rw_reg     <= rw_next;
            dw_reg     <= dw_next;
            starve_reg <= starve_next;
        end
    end

    assign WE   = we_reg;
    assign RW   = rw_reg;
    assign DW   = dw_reg;
    assign QCNT = q_count;

`ifdef GPR_WB_BYPASS_EN
    // Later matches override earlier ones: output register, then queue head..tail.
    always_comb begin
        BYP_HIT  = 1'b0;
        BYP_DATA = '0;
        if (we_reg && (rw_reg == BYP_R)) begin
            BYP_HIT  = 1'b1;
            BYP_DATA = dw_reg;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < q_count) && (q_entries[i].rt == BYP_R)) begin
                BYP_HIT  = 1'b1;
                BYP_DATA = q_entries[i].data;
            end
        end
    end
`else
    logic unused_entries;
    assign unused_entries = ^q_entries;
`endif

endmodule
